// File: rtl/lsu_rmw_if.sv
// CPU request/response and word-memory signals of the load/store unit.
// The slave modport is the unit itself; the master modport is its environment
// (CPU pipeline plus data memory).
interface lsu_rmw_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  misaligned;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic                  dmem_write_enable;
    logic [DATA_WIDTH-1:0] dmem_writedata;
    logic [DATA_WIDTH-1:0] dmem_readdata;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output dmem_readdata,
        input  req_ready, resp_valid, resp_rdata, misaligned,
        input  dmem_addr, dmem_write_enable, dmem_writedata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  dmem_readdata,
        output req_ready, resp_valid, resp_rdata, misaligned,
        output dmem_addr, dmem_write_enable, dmem_writedata
    );
endinterface

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-addressed data memory: byte addresses and
// byte/half/word accesses become word traffic, loads are sign/zero extended,
// sub-word stores are read-modify-write, misaligned/illegal accesses are
// rejected without touching memory. Only DATA_WIDTH = 32 is supported.
module lsu_rmw #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    lsu_rmw_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  req_bad;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] merge_val;

    assign bus.req_ready = (state == IDLE);

    // Reject misaligned half/word accesses and the illegal size encoding.
    always_comb begin
        case (bus.req_size)
            2'b01:   req_bad = bus.req_addr[0];
            2'b10:   req_bad = |bus.req_addr[1:0];
            2'b11:   req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
    end

    // Select the addressed little-endian lane of the read word and extend it.
    always_comb begin
        case (addr_q[1:0])
            2'b00:   lane_b = bus.dmem_readdata[7:0];
            2'b01:   lane_b = bus.dmem_readdata[15:8];
            2'b10:   lane_b = bus.dmem_readdata[23:16];
            default: lane_b = bus.dmem_readdata[31:24];
        endcase
        lane_h = addr_q[1] ? bus.dmem_readdata[31:16] : bus.dmem_readdata[15:0];
        case (size_q)
            2'b00:   load_val = {{24{signed_q & lane_b[7]}}, lane_b};
            2'b01:   load_val = {{16{signed_q & lane_h[15]}}, lane_h};
            default: load_val = bus.dmem_readdata;
        endcase
    end

    // Replace only the addressed byte/half of the read word with store data.
    always_comb begin
        merge_val = bus.dmem_readdata;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'b00:   merge_val[7:0]   = wdata_q[7:0];
                2'b01:   merge_val[15:8]  = wdata_q[7:0];
                2'b10:   merge_val[23:16] = wdata_q[7:0];
                default: merge_val[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merge_val[31:16] = wdata_q[15:0];
        end else begin
            merge_val[15:0] = wdata_q[15:0];
        end
    end

    // Access sequencer with registered memory strobes and response outputs.
    // The merged word is captured straight into dmem_writedata at the end of
    // RMW_RD, so that register doubles as the read-modify-write merge register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            addr_q                <= '0;
            size_q                <= '0;
            signed_q              <= 1'b0;
            wdata_q               <= '0;
            bus.resp_valid        <= 1'b0;
            bus.resp_rdata        <= '0;
            bus.misaligned        <= 1'b0;
            bus.dmem_addr         <= '0;
            bus.dmem_write_enable <= 1'b0;
            bus.dmem_writedata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q        <= bus.req_addr;
                        size_q        <= bus.req_size;
                        signed_q      <= bus.req_signed;
                        wdata_q       <= bus.req_wdata;
                        bus.dmem_addr <= {2'b00, bus.req_addr[ADDR_WIDTH-1:2]};
                        if (req_bad) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.misaligned <= 1'b1;
                        end else if (!bus.req_write) begin
                            state <= LOAD;
                        end else if (bus.req_size == 2'b10) begin
                            state                 <= STORE;
                            bus.dmem_write_enable <= 1'b1;
                            bus.dmem_writedata    <= bus.req_wdata;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    state          <= RESP;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= load_val;
                end
                STORE: begin
                    state                 <= RESP;
                    bus.dmem_write_enable <= 1'b0;
                    bus.resp_valid        <= 1'b1;
                end
                RMW_RD: begin
                    state                 <= RMW_WR;
                    bus.dmem_write_enable <= 1'b1;
                    bus.dmem_writedata    <= merge_val;
                end
                RMW_WR: begin
                    state                 <= RESP;
                    bus.dmem_write_enable <= 1'b0;
                    bus.resp_valid        <= 1'b1;
                end
                RESP: begin
                    state              <= IDLE;
                    bus.resp_valid     <= 1'b0;
                    bus.resp_rdata     <= '0;
                    bus.misaligned     <= 1'b0;
                    bus.dmem_addr      <= '0;
                    bus.dmem_writedata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
